// File: rtl/rv_instr_encoder_if.sv
`default_nettype none
// ============================================================================
// Module   : rv_instr_encoder_if
// Purpose  : Request / drain handshake bundle for rv_instr_encoder.
//            master = request producer and instruction-memory loader side,
//            slave  = the encoder itself.
// Revision : 1.0 - initial release
// ============================================================================
interface rv_instr_encoder_if #(
  parameter int CNT_W = 3
);
  // Request side
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_op;
  logic [4:0]       in_rd;
  logic [4:0]       in_rs1;
  logic [4:0]       in_rs2;
  logic [31:0]      in_imm;
  // Drain side
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  // Status
  logic             err;
  logic [CNT_W-1:0] count;

  modport master (
    output flush, in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, err, count
  );

  modport slave (
    input  flush, in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    output in_ready, out_valid, out_instr, err, count
  );
endinterface
`default_nettype wire

// File: rtl/rv_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : rv_instr_encoder
// Purpose  : Packs an op selector plus rd/rs1/rs2/imm into an RV32I word and
//            queues it in a small FIFO drained over valid/ready.
//            Optional macro RVENC_IMM_CHECK_EN: reject out-of-range or
//            misaligned immediates (request dropped, err pulses).
// Revision : 1.0 - initial release
// ============================================================================
module rv_instr_encoder #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 3
) (
  input  logic                clk,
  input  logic                rst,
  rv_instr_encoder_if.slave   bus
);

  localparam int c_PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [3:0] c_OP_ADD  = 4'd0;
  localparam logic [3:0] c_OP_SUB  = 4'd1;
  localparam logic [3:0] c_OP_ADDI = 4'd2;
  localparam logic [3:0] c_OP_LW   = 4'd3;
  localparam logic [3:0] c_OP_SW   = 4'd4;
  localparam logic [3:0] c_OP_BEQ  = 4'd5;
  localparam logic [3:0] c_OP_BNE  = 4'd6;
  localparam logic [3:0] c_OP_JAL  = 4'd7;

  localparam logic [6:0] c_OPC_OP     = 7'b0110011;
  localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
  localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OPC_JAL    = 7'b1101111;

  logic [31:0]        r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_err;

  logic [31:0]        w_instr;
  logic               w_legal;
  logic               w_imm_ok;
  logic               w_full;
  logic               w_accept;
  logic               w_push;
  logic               w_pop;

  logic [4:0]         w_rd;
  logic [4:0]         w_rs1;
  logic [4:0]         w_rs2;
  logic [31:0]        w_imm;

  assign w_rd  = bus.in_rd;
  assign w_rs1 = bus.in_rs1;
  assign w_rs2 = bus.in_rs2;
  assign w_imm = bus.in_imm;

  // A full FIFO refuses the push even if the head pops the same cycle, so
  // in_ready depends only on registered occupancy and flush.
  assign w_full       = (r_count == CNT_W'(FIFO_DEPTH));
  assign bus.in_ready = ~w_full & ~bus.flush;
  assign w_accept     = bus.in_valid & bus.in_ready;
  assign w_push       = w_accept & w_legal & w_imm_ok;
  assign w_pop        = (r_count != '0) & bus.out_ready & ~bus.flush;

  assign bus.out_valid = (r_count != '0);
  assign bus.out_instr = r_mem[r_rd_ptr];
  assign bus.count     = r_count;
  assign bus.err       = r_err;

  // Encode the request into its RV32I format; illegal ops flag w_legal low.
  always_comb begin
    w_instr = '0;
    w_legal = 1'b1;
    case (bus.in_op)
      c_OP_ADD:  w_instr = {7'b0000000, w_rs2, w_rs1, 3'b000, w_rd, c_OPC_OP};
      c_OP_SUB:  w_instr = {7'b0100000, w_rs2, w_rs1, 3'b000, w_rd, c_OPC_OP};
      c_OP_ADDI: w_instr = {w_imm[11:0], w_rs1, 3'b000, w_rd, c_OPC_OPIMM};
      c_OP_LW:   w_instr = {w_imm[11:0], w_rs1, 3'b010, w_rd, c_OPC_LOAD};
      c_OP_SW:   w_instr = {w_imm[11:5], w_rs2, w_rs1, 3'b010, w_imm[4:0], c_OPC_STORE};
      c_OP_BEQ:  w_instr = {w_imm[12], w_imm[10:5], w_rs2, w_rs1, 3'b000,
                            w_imm[4:1], w_imm[11], c_OPC_BRANCH};
      c_OP_BNE:  w_instr = {w_imm[12], w_imm[10:5], w_rs2, w_rs1, 3'b001,
                            w_imm[4:1], w_imm[11], c_OPC_BRANCH};
      c_OP_JAL:  w_instr = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12],
                            w_rd, c_OPC_JAL};
      default:   w_legal = 1'b0;
    endcase
  end

`ifdef RVENC_IMM_CHECK_EN
  // Immediate must sign-fit its field; branch/jump targets must be 2-byte aligned.
  always_comb begin
    w_imm_ok = 1'b1;
    case (bus.in_op)
      c_OP_ADDI, c_OP_LW, c_OP_SW:
        w_imm_ok = (w_imm[31:11] == {21{w_imm[11]}});
      c_OP_BEQ, c_OP_BNE:
        w_imm_ok = (w_imm[31:12] == {20{w_imm[12]}}) & ~w_imm[0];
      c_OP_JAL:
        w_imm_ok = (w_imm[31:20] == {12{w_imm[20]}}) & ~w_imm[0];
      default:
        w_imm_ok = 1'b1;
    endcase
  end
`else
  // Without the check the immediate is simply truncated into its field.
  logic w_unused_imm;
  assign w_unused_imm = &{1'b0, w_imm[31:21]};
  assign w_imm_ok     = 1'b1;
`endif

  // FIFO storage, pointers, occupancy and the one-cycle drop pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_err    <= 1'b0;
    end else if (bus.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_instr;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_err <= w_accept & ~(w_legal & w_imm_ok);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rv_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv_instr_encoder
// Purpose  : Self-checking bench for rv_instr_encoder: directed scenarios
//            plus a randomized run against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv_instr_encoder;

  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  rv_instr_encoder_if #(.CNT_W(CW)) bus ();

  rv_instr_encoder #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference encoder built from the field layout with shifts and masks.
  function automatic logic [31:0] ref_encode(input logic [31:0] op, input logic [31:0] rd,
                                             input logic [31:0] rs1, input logic [31:0] rs2,
                                             input logic [31:0] imm, output bit drop);
    logic [31:0] w;
    w    = 0;
    drop = (op > 7);
    case (op)
      0: w = (rs2 << 20) | (rs1 << 15) | (rd << 7) | 51;
      1: w = (32 << 25) | (rs2 << 20) | (rs1 << 15) | (rd << 7) | 51;
      2: w = ((imm & 'hFFF) << 20) | (rs1 << 15) | (rd << 7) | 19;
      3: w = ((imm & 'hFFF) << 20) | (rs1 << 15) | (2 << 12) | (rd << 7) | 3;
      4: w = (((imm >> 5) & 127) << 25) | (rs2 << 20) | (rs1 << 15) | (2 << 12)
             | ((imm & 31) << 7) | 35;
      5, 6: w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 63) << 25) | (rs2 << 20)
                | (rs1 << 15) | ((op - 5) << 12) | (((imm >> 1) & 15) << 8)
                | (((imm >> 11) & 1) << 7) | 99;
      7: w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 1023) << 21)
             | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 255) << 12) | (rd << 7) | 111;
      default: w = 0;
    endcase
`ifdef RVENC_IMM_CHECK_EN
    begin
      int s;
      s = $signed(imm);
      case (op)
        2, 3, 4: if (s < -2048 || s > 2047) drop = 1;
        5, 6:    if (s < -4096 || s > 4094 || imm[0]) drop = 1;
        7:       if (s < -1048576 || s > 1048574 || imm[0]) drop = 1;
        default: ;
      endcase
    end
`endif
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
    bus.in_valid = v;
    bus.in_op    = op;
    bus.in_rd    = rd;
    bus.in_rs1   = rs1;
    bus.in_rs2   = rs2;
    bus.in_imm   = imm;
  endtask

  task automatic do_reset();
    drive(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.count); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", bus.err); end
    checks++; if (bus.out_instr !== 32'h0) begin errors++; $display("FAIL reset_out_instr got %h want 0", bus.out_instr); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
  endtask

  task automatic test_add();
    do_reset();
    drive(1'b1, 4'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    tick();
    drive(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL add_out_valid got %b want 1", bus.out_valid); end
    checks++; if (bus.out_instr !== 32'h002081B3) begin errors++; $display("FAIL add_instr got %h want 002081b3", bus.out_instr); end
    checks++; if (bus.count !== 3'd1) begin errors++; $display("FAIL add_count got %0d want 1", bus.count); end
  endtask

  task automatic test_addi_sw();
    do_reset();
    drive(1'b1, 4'd2, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF);
    tick();
    drive(1'b1, 4'd4, 5'd0, 5'd1, 5'd2, 32'd8);
    tick();
    drive(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    checks++; if (bus.count !== 3'd2) begin errors++; $display("FAIL addisw_count got %0d want 2", bus.count); end
    checks++; if (bus.out_instr !== 32'hFFF00093) begin errors++; $display("FAIL addi_instr got %h want fff00093", bus.out_instr); end
    bus.out_ready = 1'b1;
    tick();
    checks++; if (bus.out_instr !== 32'h0020A423) begin errors++; $display("FAIL sw_instr got %h want 0020a423", bus.out_instr); end
    checks++; if (bus.count !== 3'd1) begin errors++; $display("FAIL addisw_count1 got %0d want 1", bus.count); end
    tick();
    bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL addisw_empty got %b want 0", bus.out_valid); end
  endtask

  task automatic test_beq();
    do_reset();
    drive(1'b1, 4'd5, 5'd0, 5'd1, 5'd2, 32'd8);
    tick();
    drive(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    checks++; if (bus.out_instr !== 32'h00208463) begin errors++; $display("FAIL beq_instr got %h want 00208463", bus.out_instr); end
  endtask

  task automatic test_fill_wrap();
    logic [31:0] exp_q[$];
    logic [31:0] w;
    logic [3:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    bit          drop;
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) begin
      op  = 4'($urandom_range(0, 7));
      rd  = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
      imm = 32'(($urandom_range(0, 1023) - 512) * 2);
      w = ref_encode(32'(op), 32'(rd), 32'(rs1), 32'(rs2), imm, drop);
      drive(1'b1, op, rd, rs1, rs2, imm);
      if (i < DEPTH) begin
        exp_q.push_back(w);
        tick();
      end
    end
    // Fifth request waits on a full FIFO.
    checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL fill_count got %0d want 4", bus.count); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready got %b want 0", bus.in_ready); end
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL fill_pop_in_ready got %b want 0", bus.in_ready); end
    tick();
    void'(exp_q.pop_front());
    checks++; if (bus.count !== 3'd3) begin errors++; $display("FAIL fill_pop_count got %0d want 3", bus.count); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL fill_after_in_ready got %b want 1", bus.in_ready); end
    // Fifth request now goes in, landing in the wrapped slot.
    bus.out_ready = 1'b0;
    exp_q.push_back(w);
    tick();
    drive(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL wrap_count got %0d want 4", bus.count); end
    bus.out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      checks++; if (bus.out_instr !== exp_q[i]) begin errors++; $display("FAIL wrap_order[%0d] got %h want %h", i, bus.out_instr, exp_q[i]); end
      tick();
    end
    bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL wrap_drained got %b want 0", bus.out_valid); end
  endtask

  task automatic test_illegal();
    do_reset();
    drive(1'b1, 4'd0, 5'd1, 5'd1, 5'd1, 32'd0);
    tick();
    drive(1'b1, 4'd9, 5'd1, 5'd1, 5'd1, 32'd0);
    tick();
    drive(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL illegal_err got %b want 1", bus.err); end
    checks++; if (bus.count !== 3'd1) begin errors++; $display("FAIL illegal_count got %0d want 1", bus.count); end
    tick();
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL illegal_err_clear got %b want 0", bus.err); end
    drive(1'b1, 4'd12, 5'd0, 5'd0, 5'd0, 32'd0);
    tick();
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL b2b_err0 got %b want 1", bus.err); end
    tick();
    drive(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL b2b_err1 got %b want 1", bus.err); end
    tick();
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL b2b_err_end got %b want 0", bus.err); end
    checks++; if (bus.count !== 3'd1) begin errors++; $display("FAIL b2b_count got %0d want 1", bus.count); end
  endtask

  task automatic test_imm_2048();
    do_reset();
    drive(1'b1, 4'd2, 5'd1, 5'd0, 5'd0, 32'd2048);
    tick();
    drive(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 32'd0);
`ifdef RVENC_IMM_CHECK_EN
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL imm2048_err got %b want 1", bus.err); end
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL imm2048_count got %0d want 0", bus.count); end
`else
    checks++; if (bus.out_instr !== 32'h80000093) begin errors++; $display("FAIL imm2048_instr got %h want 80000093", bus.out_instr); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL imm2048_err got %b want 0", bus.err); end
`endif
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'd0, 5'(i + 1), 5'd1, 5'd2, 32'd0);
      tick();
    end
    bus.flush = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b want 0", bus.in_ready); end
    tick();
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL flush_count got %0d want 0", bus.count); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got %b want 0", bus.out_valid); end
  endtask

  task automatic test_rst_mid();
    do_reset();
    drive(1'b1, 4'd1, 5'd4, 5'd5, 5'd6, 32'd0);
    tick();
    tick();
    drive(1'b1, 4'd14, 5'd0, 5'd0, 5'd0, 32'd0);
    tick();
    drive(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL rstmid_pre_err got %b want 1", bus.err); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL rstmid_count got %0d want 0", bus.count); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.out_instr !== 32'h0) begin errors++; $display("FAIL rstmid_out_instr got %h want 0", bus.out_instr); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL rstmid_err got %b want 0", bus.err); end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] q[$];
    bit          exp_err;
    bit          exp_ready;
    bit          accept;
    bit          drop;
    logic [31:0] w;
    logic [3:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    do_reset();
    exp_err = 0;
    for (int c = 0; c < 400; c++) begin
      op  = ($urandom_range(0, 9) == 0) ? 4'(8 + $urandom_range(0, 7)) : 4'($urandom_range(0, 7));
      rd  = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
      case ($urandom_range(0, 3))
        0:       imm = 32'($urandom_range(0, 4095)) - 32'd2048;
        1:       imm = 32'($urandom_range(0, 8191)) - 32'd4096;
        2:       imm = 32'($urandom_range(0, 32'h1F_FFFF)) - 32'h10_0000;
        default: imm = $urandom;
      endcase
      drive(1'($urandom_range(0, 3) != 0), op, rd, rs1, rs2, imm);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      bus.flush     = ($urandom_range(0, 30) == 0);
      #1;
      exp_ready = (q.size() != DEPTH) && !bus.flush;
      checks++; if (bus.count !== 3'(q.size())) begin errors++; $display("FAIL rnd_count c=%0d got %0d want %0d", c, bus.count, q.size()); end
      checks++; if (bus.out_valid !== (q.size() != 0)) begin errors++; $display("FAIL rnd_out_valid c=%0d got %b want %b", c, bus.out_valid, q.size() != 0); end
      checks++; if (bus.err !== exp_err) begin errors++; $display("FAIL rnd_err c=%0d got %b want %b", c, bus.err, exp_err); end
      checks++; if (bus.in_ready !== exp_ready) begin errors++; $display("FAIL rnd_in_ready c=%0d got %b want %b", c, bus.in_ready, exp_ready); end
      if (q.size() != 0) begin
        checks++; if (bus.out_instr !== q[0]) begin errors++; $display("FAIL rnd_out_instr c=%0d got %h want %h", c, bus.out_instr, q[0]); end
      end
      accept = bus.in_valid && exp_ready;
      w = ref_encode(32'(op), 32'(rd), 32'(rs1), 32'(rs2), imm, drop);
      if (bus.flush) begin
        q.delete();
        exp_err = 0;
      end else begin
        if (q.size() != 0 && bus.out_ready) void'(q.pop_front());
        if (accept && !drop) q.push_back(w);
        exp_err = accept && drop;
      end
      tick();
    end
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    test_reset();
    test_add();
    test_addi_sw();
    test_beq();
    test_fill_wrap();
    test_illegal();
    test_imm_2048();
    test_flush();
    test_rst_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
